div6_seq: RTL and testbench

DIV6_SEQ -- requirements
Module: div6_seq

---
 rtl/div6_seq.sv | 134 +++++++++++++
 tb/tb_div6_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div6_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones / dividend with a flag.
module div6_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       stateDbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateE;

    stateE            state, stateNext;
    logic [CW-1:0]    stepCnt, stepCntNext;
    logic [WIDTH:0]   partRem, partRemNext;
    logic [WIDTH-1:0] shiftReg, shiftRegNext;
    logic [WIDTH-1:0] divReg, divRegNext;
    logic             busyNext, doneNext, dbzNext;
    logic [WIDTH-1:0] quotientNext, remainderNext;

    // One row of subtract-or-pass cells; the borrow-out selects pass-through.
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH:0]   stepRem;
    logic [WIDTH-1:0] stepShift;
    // P stays below the divisor after every step, so its top bit never feeds the next trial.
    logic             unusedPartMsb;

    assign trial         = {partRem[WIDTH-1:0], shiftReg[WIDTH-1]};
    assign diff          = {1'b0, trial} - {2'b00, divReg};
    assign borrow        = diff[WIDTH+1];
    assign stepRem       = borrow ? trial : diff[WIDTH:0];
    assign stepShift     = {shiftReg[WIDTH-2:0], ~borrow};
    assign unusedPartMsb = partRem[WIDTH];
    assign stateDbg      = state;

    always_comb begin
        stateNext     = state;
        stepCntNext   = stepCnt;
        partRemNext   = partRem;
        shiftRegNext  = shiftReg;
        divRegNext    = divReg;
        busyNext      = busy;
        doneNext      = 1'b0;
        quotientNext  = quotient;
        remainderNext = remainder;
        dbzNext       = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    busyNext = 1'b1;
                    if (divisor == '0) begin
                        stateNext     = DONE;
                        doneNext      = 1'b1;
                        quotientNext  = '1;
                        remainderNext = dividend;
                        dbzNext       = 1'b1;
                    end else begin
                        stateNext    = RUN;
                        stepCntNext  = '0;
                        partRemNext  = '0;
                        shiftRegNext = dividend;
                        divRegNext   = divisor;
                    end
                end
            end
            RUN: begin
                partRemNext  = stepRem;
                shiftRegNext = stepShift;
                if (stepCnt == LAST_STEP) begin
                    stateNext     = DONE;
                    stepCntNext   = '0;
                    doneNext      = 1'b1;
                    quotientNext  = stepShift;
                    remainderNext = stepRem[WIDTH-1:0];
                    dbzNext       = 1'b0;
                end else begin
                    stepCntNext = stepCnt + CW'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            stepCnt     <= '0;
            partRem     <= '0;
            shiftReg    <= '0;
            divReg      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= stateNext;
            stepCnt     <= stepCntNext;
            partRem     <= partRemNext;
            shiftReg    <= shiftRegNext;
            divReg      <= divRegNext;
            busy        <= busyNext;
            done        <= doneNext;
            quotient    <= quotientNext;
            remainder   <= remainderNext;
            div_by_zero <= dbzNext;
        end
    end

endmodule

// File: tb/tb_div6_seq.sv
// Directed bench for div6_seq: scenario tasks with inline checks, then a full operand sweep.
// Inputs change and outputs are sampled on the falling edge.
module tb_div6_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;
    logic [1:0] stateDbg;

    int nChecks = 0;
    int nFails  = 0;

    div6_seq #(.WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .stateDbg   (stateDbg)
    );

    always #5 clk = ~clk;

    // Present operands for one edge; returns at the falling edge just after the accepting edge.
    task automatic drive_start(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 6'd45;
        divisor  = 6'd7;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({busy, done, div_by_zero, stateDbg} !== 5'b0) begin
            nFails++;
            $display("FAIL reset_ctrl: got busy=%b done=%b dbz=%b state=%0d expected all 0",
                     busy, done, div_by_zero, stateDbg);
        end
        nChecks++;
        if ({quotient, remainder} !== 12'd0) begin
            nFails++;
            $display("FAIL reset_data: got q=%0d r=%0d expected 0 0", quotient, remainder);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b0 || stateDbg !== 2'd0) begin
            nFails++;
            $display("FAIL idle_hold: got busy=%b state=%0d expected 0 0", busy, stateDbg);
        end
    endtask

    task automatic test_basic();
        int busyCnt = 0;
        int doneCnt = 0;
        int doneAt  = -1;
        bit heldOk  = 1'b1;
        logic [5:0] capQ = '0;
        logic [5:0] capR = '0;
        logic capZ = 1'b1;
        drive_start(6'd45, 6'd7);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) begin
                doneCnt++;
                doneAt = i;
                capQ = quotient;
                capR = remainder;
                capZ = div_by_zero;
            end
            if (i < 6 && (quotient !== 6'd0 || remainder !== 6'd0)) heldOk = 1'b0;
        end
        nChecks++;
        if (busyCnt != 7) begin
            nFails++;
            $display("FAIL basic_busy_cycles: got %0d expected 7", busyCnt);
        end
        nChecks++;
        if (doneCnt != 1 || doneAt != 6) begin
            nFails++;
            $display("FAIL basic_done_timing: got %0d pulses at %0d expected 1 at 6", doneCnt, doneAt);
        end
        nChecks++;
        if (capQ !== 6'd6 || capR !== 6'd3 || capZ !== 1'b0) begin
            nFails++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected 6 3 0", capQ, capR, capZ);
        end
        nChecks++;
        if (!heldOk) begin
            nFails++;
            $display("FAIL basic_held_in_run: got changing outputs expected 0 0 until done");
        end
        nChecks++;
        if (quotient !== 6'd6 || remainder !== 6'd3) begin
            nFails++;
            $display("FAIL basic_hold_after: got q=%0d r=%0d expected 6 3", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int doneAt[$];
        logic [11:0] res[$];
        logic busyGap = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd63;
        divisor  = 6'd1;
        @(negedge clk);
        dividend = 6'd5;
        divisor  = 6'd9;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if (done === 1'b1) begin
                doneAt.push_back(i);
                res.push_back({quotient, remainder});
            end
            if (i == 7) busyGap = busy;
        end
        start = 1'b0;
        nChecks++;
        if (doneAt.size() != 2) begin
            nFails++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", doneAt.size());
        end else begin
            nChecks++;
            if (doneAt[0] != 6 || doneAt[1] != 14) begin
                nFails++;
                $display("FAIL b2b_timing: got %0d,%0d expected 6,14", doneAt[0], doneAt[1]);
            end
            nChecks++;
            if (res[0] !== {6'd63, 6'd0}) begin
                nFails++;
                $display("FAIL b2b_first: got q=%0d r=%0d expected 63 0", res[0][11:6], res[0][5:0]);
            end
            nChecks++;
            if (res[1] !== {6'd0, 6'd5}) begin
                nFails++;
                $display("FAIL b2b_second: got q=%0d r=%0d expected 0 5", res[1][11:6], res[1][5:0]);
            end
        end
        nChecks++;
        if (busyGap !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_idle_gap: got busy=%b expected 0", busyGap);
        end
    endtask

    task automatic test_div_zero();
        drive_start(6'd10, 6'd0);
        nChecks++;
        if (done !== 1'b1 || busy !== 1'b1 || stateDbg !== 2'd2) begin
            nFails++;
            $display("FAIL dz_done_now: got done=%b busy=%b state=%0d expected 1 1 2", done, busy, stateDbg);
        end
        nChecks++;
        if (quotient !== 6'd63 || remainder !== 6'd10 || div_by_zero !== 1'b1) begin
            nFails++;
            $display("FAIL dz_result: got q=%0d r=%0d dbz=%b expected 63 10 1", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 6'd63) begin
            nFails++;
            $display("FAIL dz_after: got done=%b busy=%b dbz=%b q=%0d expected 0 0 1 63", done, busy, div_by_zero, quotient);
        end
    endtask

    task automatic test_reset_mid_run();
        bit doneSeen = 1'b0;
        int lat;
        drive_start(6'd50, 6'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nChecks++;
        if ({busy, done, div_by_zero, stateDbg} !== 5'b0 || {quotient, remainder} !== 12'd0) begin
            nFails++;
            $display("FAIL midreset_clear: got busy=%b done=%b dbz=%b state=%0d q=%0d r=%0d expected all 0",
                     busy, done, div_by_zero, stateDbg, quotient, remainder);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen = 1'b1;
        end
        nChecks++;
        if (doneSeen) begin
            nFails++;
            $display("FAIL midreset_no_done: got activity after reset expected none");
        end
        drive_start(6'd50, 6'd3);
        wait_done(lat);
        nChecks++;
        if (lat != 6 || quotient !== 6'd16 || remainder !== 6'd2 || div_by_zero !== 1'b0) begin
            nFails++;
            $display("FAIL midreset_rerun: got lat=%0d q=%0d r=%0d dbz=%b expected 6 16 2 0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_ignored();
        int doneCnt = 0;
        int doneAt  = -1;
        logic [11:0] cap = '0;
        drive_start(6'd20, 6'd6);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (done === 1'b1) begin
                doneCnt++;
                doneAt = i;
                cap = {quotient, remainder};
            end
            if (i == 2) begin
                start    = 1'b1;
                dividend = 6'd63;
                divisor  = 6'd63;
            end
            if (i == 3) begin
                start    = 1'b0;
                dividend = 6'd33;
                divisor  = 6'd1;
            end
        end
        nChecks++;
        if (doneCnt != 1 || doneAt != 6) begin
            nFails++;
            $display("FAIL ignore_pulses: got %0d pulses at %0d expected 1 at 6", doneCnt, doneAt);
        end
        nChecks++;
        if (cap !== {6'd3, 6'd2}) begin
            nFails++;
            $display("FAIL ignore_result: got q=%0d r=%0d expected 3 2", cap[11:6], cap[5:0]);
        end
    endtask

    task automatic test_sweep();
        int lat;
        int expLat;
        logic [5:0] expQ;
        logic [5:0] expR;
        logic expZ;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                drive_start(6'(a), 6'(b));
                wait_done(lat);
                if (b == 0) begin
                    expQ = 6'd63;
                    expR = 6'(a);
                    expZ = 1'b1;
                    expLat = 0;
                end else begin
                    expQ = 6'(a / b);
                    expR = 6'(a % b);
                    expZ = 1'b0;
                    expLat = 6;
                end
                nChecks++;
                if (lat != expLat) begin
                    nFails++;
                    $display("FAIL sweep_latency %0d/%0d: got %0d expected %0d", a, b, lat, expLat);
                end
                nChecks++;
                if (quotient !== expQ || remainder !== expR || div_by_zero !== expZ) begin
                    nFails++;
                    $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%b expected %0d %0d %b",
                             a, b, quotient, remainder, div_by_zero, expQ, expR, expZ);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_div_zero();
        test_reset_mid_run();
        test_start_ignored();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
